// File: rtl/alu_exec_pkg.sv
// Shared opcode encodings, multiplier step count and FSM state type for alu_exec.
package alu_exec_pkg;

  localparam int unsigned OP_W      = 4;
  localparam int unsigned MUL_STEPS = 16;
  localparam int unsigned CNT_W     = 5;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL = 4'd8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle.
module alu_mul_seq
  import alu_exec_pkg::*;
#(
  parameter int unsigned DWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DWIDTH-1:0]     a,
  input  logic [DWIDTH-1:0]     b,
  output logic [2*DWIDTH-1:0]   product_c,
  output logic                  done_c
);

  localparam int unsigned PW = 2 * DWIDTH;

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    mcand_q;
  logic [DWIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    addend_c;
  logic [PW-1:0]    acc_next_c;

  // Next accumulator value; on the final step it is the full product.
  always_comb begin
    addend_c   = mplier_q[0] ? mcand_q : '0;
    acc_next_c = acc_q + addend_c;
    product_c  = acc_next_c;
    done_c     = run_q && (cnt_q == CNT_W'(MUL_STEPS - 1));
  end

  // Operand latch on start, then one shift-add step per cycle while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= PW'(a);
      mplier_q <= b;
      acc_q    <= '0;
    end else if (run_q) begin
      acc_q    <= acc_next_c;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (done_c) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops with flags, plus a 16-step sequential multiply.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int unsigned DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic [DWIDTH-1:0] alu_a,
  input  logic [DWIDTH-1:0] alu_b,
  input  logic [OP_W-1:0]   alu_op,
  output logic [DWIDTH-1:0] alu_out,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v,
  output logic              en_out,
  output logic              busy
);

  localparam int unsigned PW = 2 * DWIDTH;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] out_d;
  logic              z_d, n_d, c_d, v_d, en_out_d, busy_d;

  logic [DWIDTH-1:0] res_c;
  logic              c_c, v_c;
  logic [DWIDTH:0]   sum_c;
  logic [DWIDTH-1:0] diff_c;
  logic [DWIDTH:0]   shl_c;
  logic [DWIDTH:0]   shr_c;
  logic [3:0]        shamt_c;

  logic              mul_start_c;
  logic              mul_done_c;
  logic [PW-1:0]     mul_prod_c;
  logic [DWIDTH-1:0] mul_lo_c;

  alu_mul_seq #(.DWIDTH(DWIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start_c),
    .a         (alu_a),
    .b         (alu_b),
    .product_c (mul_prod_c),
    .done_c    (mul_done_c)
  );

  // Single-cycle datapath; shifts carry an extra bit to expose the last bit shifted out.
  always_comb begin
    res_c   = '0;
    c_c     = 1'b0;
    v_c     = 1'b0;
    shamt_c = alu_b[3:0];
    sum_c   = {1'b0, alu_a} + {1'b0, alu_b};
    diff_c  = alu_a - alu_b;
    shl_c   = {1'b0, alu_a} << shamt_c;
    shr_c   = {alu_a, 1'b0} >> shamt_c;
    case (alu_op)
      OP_ADD: begin
        res_c = sum_c[DWIDTH-1:0];
        c_c   = sum_c[DWIDTH];
        v_c   = (alu_a[DWIDTH-1] == alu_b[DWIDTH-1]) &&
                (sum_c[DWIDTH-1] != alu_a[DWIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff_c;
        c_c   = alu_a < alu_b;
        v_c   = (alu_a[DWIDTH-1] != alu_b[DWIDTH-1]) &&
                (diff_c[DWIDTH-1] != alu_a[DWIDTH-1]);
      end
      OP_AND: res_c = alu_a & alu_b;
      OP_OR:  res_c = alu_a | alu_b;
      OP_XOR: res_c = alu_a ^ alu_b;
      OP_NOT: res_c = ~alu_a;
      OP_SHL: begin
        res_c = shl_c[DWIDTH-1:0];
        c_c   = shl_c[DWIDTH];
      end
      OP_SHR: begin
        res_c = shr_c[DWIDTH:1];
        c_c   = shr_c[0];
      end
      default: res_c = '0;
    endcase
  end

  assign mul_lo_c = mul_prod_c[DWIDTH-1:0];

  // Next-state and next-output logic; outputs hold unless a result is produced.
  always_comb begin
    state_d     = state_q;
    out_d       = alu_out;
    z_d         = flag_z;
    n_d         = flag_n;
    c_d         = flag_c;
    v_d         = flag_v;
    en_out_d    = 1'b0;
    busy_d      = busy;
    mul_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_in) begin
          if (alu_op == OP_MUL) begin
            mul_start_c = 1'b1;
            busy_d      = 1'b1;
            state_d     = ST_MUL_RUN;
          end else begin
            out_d    = res_c;
            z_d      = (res_c == '0);
            n_d      = res_c[DWIDTH-1];
            c_d      = c_c;
            v_d      = v_c;
            en_out_d = 1'b1;
          end
        end
      end
      ST_MUL_RUN: begin
        if (mul_done_c) begin
          out_d    = mul_lo_c;
          z_d      = (mul_lo_c == '0);
          n_d      = mul_lo_c[DWIDTH-1];
          c_d      = |mul_prod_c[PW-1:DWIDTH];
          v_d      = 1'b0;
          en_out_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      alu_out <= '0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      en_out  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      alu_out <= out_d;
      flag_z  <= z_d;
      flag_n  <= n_d;
      flag_c  <= c_d;
      flag_v  <= v_d;
      en_out  <= en_out_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed vectors with hand-computed results.
module tb_alu_exec;

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_in;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_out;
  logic        flag_z, flag_n, flag_c, flag_v;
  logic        en_out;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   run_len = 0;
  int   max_run = 0;

  alu_exec #(.DWIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_in   (en_in),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_out (alu_out),
    .flag_z  (flag_z),
    .flag_n  (flag_n),
    .flag_c  (flag_c),
    .flag_v  (flag_v),
    .en_out  (en_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [15:0] r, input logic z, input logic n,
                              input logic c, input logic v);
    exp_t e;
    e.r = r; e.z = z; e.n = n; e.c = c; e.v = v;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pop and compare one expected result per en_out cycle.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (rst_n && en_out) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      got = mk(alu_out, flag_z, flag_n, flag_c, flag_v);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_en_out: got out=0x%0h with empty scoreboard", alu_out);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL result: got r=0x%0h z%0b n%0b c%0b v%0b expected r=0x%0h z%0b n%0b c%0b v%0b",
                   got.r, got.z, got.n, got.c, got.v, want.r, want.z, want.n, want.c, want.v);
        end
      end
    end else begin
      run_len = 0;
    end
  end

  // Present one operation for a single cycle; caller is at posedge+1.
  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    en_in = 1'b1; alu_op = op; alu_a = a; alu_b = b;
    @(posedge clk); #1;
    en_in = 1'b0;
  endtask

  task automatic op1(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input exp_t e);
    exp_q.push_back(e);
    drive(op, a, b);
  endtask

  // Issue a MUL and measure busy cycles and accept-to-en_out latency.
  task automatic mul_timed(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    int n;
    int busy_cnt;
    exp_q.push_back(e);
    drive(4'd8, a, b);
    busy_cnt = 0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (en_out) break;
      if (busy) busy_cnt++;
      n++;
    end
    check("mul_latency", 32'(n), 32'd16);
    check("mul_busy_cycles", 32'(busy_cnt), 32'd16);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en_in = 1'b0; alu_a = '0; alu_b = '0; alu_op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'(alu_out), 32'd0);
    check("reset_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    check("reset_en_busy", 32'({en_out, busy}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops: r, z, n, c, v
    op1(4'd0, 16'h7FFF, 16'h0001, mk(16'h8000, 0, 1, 0, 1));
    op1(4'd1, 16'h0000, 16'h0001, mk(16'hFFFF, 0, 1, 1, 0));
    op1(4'd7, 16'h8001, 16'h0001, mk(16'h4000, 0, 0, 1, 0));
    op1(4'd2, 16'hF0F0, 16'h0FF0, mk(16'h00F0, 0, 0, 0, 0));
    op1(4'd3, 16'h0F00, 16'h00F0, mk(16'h0FF0, 0, 0, 0, 0));
    op1(4'd4, 16'hFFFF, 16'hFFFF, mk(16'h0000, 1, 0, 0, 0));
    op1(4'd5, 16'h0000, 16'h1234, mk(16'hFFFF, 0, 1, 0, 0));
    op1(4'd6, 16'h8001, 16'h0001, mk(16'h0002, 0, 0, 1, 0));
    op1(4'd6, 16'h8000, 16'h0010, mk(16'h8000, 0, 1, 0, 0));
    op1(4'd6, 16'h0001, 16'h000F, mk(16'h8000, 0, 1, 0, 0));
    op1(4'd15, 16'h0001, 16'h0001, mk(16'h0000, 1, 0, 0, 0));
    op1(4'd0, 16'hFFFF, 16'h0001, mk(16'h0000, 1, 0, 1, 0));
    op1(4'd1, 16'h8000, 16'h0001, mk(16'h7FFF, 0, 0, 0, 1));
    repeat (2) @(posedge clk);
    #1;
    check("hold_out", 32'(alu_out), 32'h7FFF);
    check("hold_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'b0001);

    // Multiplies
    mul_timed(16'h0100, 16'h0100, mk(16'h0000, 1, 0, 1, 0));
    mul_timed(16'h00FF, 16'h0003, mk(16'h02FD, 0, 0, 0, 0));

    // en_in during MUL_RUN is ignored; ADD right as busy falls is accepted
    exp_q.push_back(mk(16'h0023, 0, 0, 0, 0));
    drive(4'd8, 16'h0005, 16'h0007);
    repeat (3) @(posedge clk);
    #1;
    drive(4'd0, 16'h0001, 16'h0001);
    n = 0;
    while (n < 30) begin
      @(posedge clk); #1;
      if (!busy) break;
      n++;
    end
    check("busy_fall_timeout", 32'(n < 30), 32'd1);
    op1(4'd0, 16'h0001, 16'h0001, mk(16'h0002, 0, 0, 0, 0));
    @(posedge clk); #1;

    // Reset at the 8th step aborts the multiply
    drive(4'd8, 16'hFFFF, 16'hFFFF);
    repeat (7) @(posedge clk);
    #1;
    check("busy_mid_mul", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out", 32'(alu_out), 32'd0);
    check("abort_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    check("abort_en_busy", 32'({en_out, busy}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_result_busy", 32'(busy), 32'd0);

    // Ten back-to-back ADDs
    max_run = 0;
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(mk(16'(2 * i), 0, 0, 0, 0));
      en_in = 1'b1; alu_op = 4'd0; alu_a = 16'(i); alu_b = 16'(i);
      @(posedge clk); #1;
    end
    en_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_run_len", 32'(max_run), 32'd10);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound on simulation time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: DWIDTH, default 16, operand/result width; all arithmetic rules below are stated for 16 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en_in  input  1  operands valid (registered operand strobe from the operand-select stage).
REQ-005 alu_a  input  DWIDTH  operand A (registered, from the operand-select stage).
REQ-006 alu_b  input  DWIDTH  operand B (registered, from the operand-select stage).
REQ-007 alu_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 SHR, 8 MUL, 9-15 reserved.
REQ-008 alu_out  output  DWIDTH  registered result.
REQ-009 flag_z, flag_n, flag_c, flag_v  output  1 each  zero, negative, carry/borrow, signed overflow; registered with alu_out.
REQ-010 en_out  output  1  one-cycle pulse marking alu_out/flags valid.
REQ-011 busy  output  1  high while a MUL is in progress; upstream holds en_in low while busy is high.

Function
REQ-012 The FSM SHALL have two states: IDLE and MUL_RUN.
REQ-013 In IDLE, en_in=1 with a non-MUL op SHALL register the result and flags at that edge and assert en_out for exactly one cycle (latency 1).
REQ-014 ADD: {C,R}=A+B; V=1 when A and B share a sign and R differs from it.
REQ-015 SUB: R=A-B; C=1 (borrow) when A<B unsigned; V=1 when A and B differ in sign and R's sign differs from A.
REQ-016 AND/OR/XOR: bitwise A op B. NOT: R=~A, B ignored. C=0, V=0 for all four.
REQ-017 SHL/SHR: logical shift of A by B[3:0]; C=last bit shifted out, C=0 when B[3:0]=0; V=0.
REQ-018 Reserved ops: R=0, all flags 0 except Z=1; en_out still pulses.
REQ-019 For every op: Z=(R==0), N=R[15].
REQ-020 MUL: en_in=1 in IDLE SHALL latch A and B, clear the accumulator, and enter MUL_RUN; busy=1 from the next cycle.
REQ-021 MUL_RUN SHALL perform one unsigned shift-add step per cycle for 16 cycles, using a 5-bit iteration counter.
REQ-022 On the 16th step edge: alu_out = product[15:0]; C = |product[31:16]; V=0; Z and N from alu_out; en_out=1 for one cycle; busy=0; state returns to IDLE. Latency from the accept edge to en_out is 16 cycles.
REQ-023 en_in while in MUL_RUN SHALL be ignored with no effect on state, outputs or result.
REQ-024 en_in=1 in the first cycle after busy falls SHALL be accepted normally.
REQ-025 Back-to-back single-cycle ops (en_in high every cycle) SHALL each produce a result, with en_out high continuously.
REQ-026 When en_out=0, alu_out and the flags SHALL hold their last values.

Reset
REQ-027 rst_n=0 SHALL immediately force: alu_out=0, all flags=0, en_out=0, busy=0, state=IDLE, counter=0, multiplier registers=0.
REQ-028 Reset asserted during MUL_RUN SHALL abort the multiply; no en_out is produced for the aborted op.

Structure
REQ-029 Opcode encodings and the MUL step count (16) SHALL be defined as constants in a shared header, alu_defs.vh, which is also used by the decoder.
REQ-030 The iterative multiplier (latched operands, accumulator, counter, done strobe) SHALL be a sub-module named alu_mul_seq; alu_exec holds the FSM, the single-cycle datapath and the output registers.

Verification
REQ-031 ADD A=0x7FFF, B=0x0001 -> next cycle alu_out=0x8000, N=1, V=1, C=0, Z=0, en_out pulse of 1 cycle.
REQ-032 SUB A=0x0000, B=0x0001 -> alu_out=0xFFFF, C=1, N=1, V=0; SHR A=0x8001, B=0x0001 -> alu_out=0x4000, C=1.
REQ-033 MUL A=0x0100, B=0x0100 -> busy high for 16 cycles; en_out 16 cycles after accept; alu_out=0x0000, Z=1, C=1. MUL 0x00FF*0x0003 -> 0x02FD, C=0.
REQ-034 During a MUL, pulse en_in with ADD 1+1 -> ignored: exactly one en_out, carrying the MUL result; an ADD presented the cycle busy falls -> result 0x0002.
REQ-035 Assert rst_n=0 at the 8th MUL step -> all outputs 0 immediately; after release, no en_out until a new en_in.
REQ-036 Ten consecutive ADDs of i+i, one per cycle -> ten consecutive en_out cycles with alu_out=2i in order.
